// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter
// Two-requester Avalon-MM read arbiter in front of a single f2h_sdram port.
// m0 (pixel fetch) normally wins and m1 (auxiliary) is served when m0 is idle.
// At most one burst is in flight: IDLE -> CMD -> DATA -> IDLE.
// Optional build macro ARB_STARVE_GUARD_EN adds a starve counter.
// After STARVE_LIMIT consecutive m0 bursts accepted while m1 was waiting,
// m1 is granted next. Without the macro, arbitration is strict m0 > m1.
// s_readdatavalid seen outside DATA is dropped and latched into stray_o.
module sdram_read_arbiter #(
    parameter int ADDR_W       = 29,
    parameter int BURST_W      = 8,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [ADDR_W-1:0]  s_address,
    output logic [BURST_W-1:0] s_burstcount,
    output logic               s_read,
    input  logic               s_waitrequest,
    input  logic [DATA_W-1:0]  s_readdata,
    input  logic               s_readdatavalid,
    output logic               busy_o,
    output logic               stray_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic               owner_reg, owner_next;   // 0 = m0, 1 = m1
    logic [BURST_W-1:0] beat_reg, beat_next;
    logic               stray_reg, stray_next;
    logic               grant_m1;                // IDLE decision when anyone requests
    logic               cmd_accept;
    logic               in_cmd, in_data;
    logic [ADDR_W-1:0]  sel_address;
    logic [BURST_W-1:0] sel_burstcount;
    logic [1:0]         wait_vec, rdv_vec;

    assign sel_address    = owner_reg ? m1_address    : m0_address;
    assign sel_burstcount = owner_reg ? m1_burstcount : m0_burstcount;
    assign cmd_accept     = (state_reg == ST_CMD) && !s_waitrequest;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_reg, starve_next;

    assign grant_m1 = m1_read && (!m0_read || (starve_reg == STARVE_MAX));

    // Count m0 bursts taken while m1 was waiting; any other accept clears it.
    always_comb begin
        starve_next = starve_reg;
        if (cmd_accept) begin
            if (owner_reg || !m1_read) begin
                starve_next = '0;
            end else if (starve_reg != STARVE_MAX) begin
                starve_next = starve_reg + 1'b1;
            end
        end
    end

    // Starve counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end
`else
    assign grant_m1 = m1_read && !m0_read;
`endif

    // Burst sequencing, beat counting and stray-beat detection.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        beat_next  = beat_reg;
        stray_next = stray_reg | (s_readdatavalid && (state_reg != ST_DATA));
        case (state_reg)
            ST_IDLE: begin
                if (m0_read || m1_read) begin
                    owner_next = grant_m1;
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!s_waitrequest) begin
                    // A zero burstcount still returns one beat.
                    beat_next  = (sel_burstcount == '0) ? BURST_W'(1) : sel_burstcount;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_readdatavalid) begin
                    beat_next = beat_reg - 1'b1;
                    if (beat_reg <= BURST_W'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b0;
            beat_reg  <= '0;
            stray_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            beat_reg  <= beat_next;
            stray_reg <= stray_next;
        end
    end

    // Outputs are masked by rst so a mid-burst reset takes effect immediately.
    assign in_cmd  = (state_reg == ST_CMD)  && !rst;
    assign in_data = (state_reg == ST_DATA) && !rst;

    assign s_read       = in_cmd;
    assign s_address    = in_cmd ? sel_address    : '0;
    assign s_burstcount = in_cmd ? sel_burstcount : '0;
    assign busy_o       = in_cmd || in_data;
    assign stray_o      = stray_reg;

    // Per-requester handshake: only the owner sees the slave's stall/valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic is_owner;
            assign is_owner     = (owner_reg == 1'(gi));
            assign wait_vec[gi] = (in_cmd && is_owner) ? s_waitrequest : 1'b1;
            assign rdv_vec[gi]  = in_data && is_owner && s_readdatavalid;
        end
    endgenerate

    assign m0_waitrequest   = wait_vec[0];
    assign m1_waitrequest   = wait_vec[1];
    assign m0_readdatavalid = rdv_vec[0];
    assign m1_readdatavalid = rdv_vec[1];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// tb_sdram_read_arbiter
// Table of single-requester bursts, plus sequences for a mid-burst reset
// and for arbitration with both requesters held high. Returned beats are
// checked against a queue of expected {owner, data} records.
// The grant-order expectation follows ARB_STARVE_GUARD_EN.
module tb_sdram_read_arbiter;

    localparam int ADDR_W  = 29;
    localparam int BURST_W = 8;
    localparam int DATA_W  = 64;

    logic               clk;
    logic               rst;
    logic [ADDR_W-1:0]  m0_address, m1_address;
    logic [BURST_W-1:0] m0_burstcount, m1_burstcount;
    logic               m0_read, m1_read;
    logic               m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]  m0_readdata, m1_readdata;
    logic               m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0]  s_address;
    logic [BURST_W-1:0] s_burstcount;
    logic               s_read;
    logic               s_waitrequest;
    logic [DATA_W-1:0]  s_readdata;
    logic               s_readdatavalid;
    logic               busy_o;
    logic               stray_o;

    sdram_read_arbiter #(
        .ADDR_W(ADDR_W), .BURST_W(BURST_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .busy_o(busy_o), .stray_o(stray_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [63:0] d;
    } beat_t;

    typedef struct {
        int                 m;
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] bc;
        int                 waits;
        int                 beats;   // expected returned beats
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[5];
    int    tests_run    = 0;
    int    tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int m, input logic rd, input logic [ADDR_W-1:0] a,
                             input logic [BURST_W-1:0] b);
        if (m == 0) begin
            m0_read = rd; m0_address = a; m0_burstcount = b;
        end else begin
            m1_read = rd; m1_address = a; m1_burstcount = b;
        end
    endtask

    // Beat monitor: every delivered beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (m0_readdatavalid && m1_readdatavalid) begin
            check("both_rdv", 1'b1, 1'b0);
        end else if (m0_readdatavalid || m1_readdatavalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rdv", {63'd0, m1_readdatavalid}, 64'hFFFF);
            end else begin
                beat_t e;
                e = sb.pop_front();
                $display("[TB] beat m%0d data %016h", m1_readdatavalid ? 1 : 0, s_readdata);
                check("rdv_owner", {63'd0, m1_readdatavalid}, e.m[0] ? 64'd1 : 64'd0);
                check("m0_readdata", m0_readdata, e.d);
                check("m1_readdata", m1_readdata, e.d);
            end
        end
    end

    // One burst from a single requester, with optional command stall.
    task automatic run_burst(input int m, input logic [ADDR_W-1:0] addr,
                             input logic [BURST_W-1:0] bc, input int waits, input int beats);
        logic [63:0] d;
        @(posedge clk); #1;
        drive_req(m, 1'b1, addr, bc);
        #1;
        check("idle_s_read", s_read, 0);
        check("idle_busy", busy_o, 0);
        for (int c = 0; c <= waits; c++) begin
            @(posedge clk); #1;
            s_waitrequest = (c < waits);
            #1;
            check("cmd_s_read", s_read, 1);
            check("cmd_address", s_address, addr);
            check("cmd_burstcount", s_burstcount, bc);
            check("owner_wait", (m == 0) ? m0_waitrequest : m1_waitrequest, s_waitrequest);
            check("nonowner_wait", (m == 0) ? m1_waitrequest : m0_waitrequest, 1);
        end
        @(posedge clk); #1;
        drive_req(m, 1'b0, addr, bc);
        s_waitrequest = 1'b0;
        for (int b = 0; b < beats; b++) begin
            if (b > 0) begin
                @(posedge clk); #1;
            end
            if (b == 1) begin
                s_readdatavalid = 1'b0;
                #1;
                check("gap_busy", busy_o, 1);
                @(posedge clk); #1;
            end
            d = {$urandom, $urandom};
            s_readdata      = d;
            s_readdatavalid = 1'b1;
            sb.push_back('{m, d});
            #1;
            check("data_busy", busy_o, 1);
            check("data_s_read", s_read, 0);
            check("data_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        end
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;
        #1;
        check("busy_after_last", busy_o, 0);
        check("sb_drained", sb.size(), 0);
        $display("[TB] burst m%0d addr %0h bc %0d waits %0d beats %0d", m, addr, bc, waits, beats);
    endtask

    // With both requests held high, serve one 1-beat burst and report the owner.
    task automatic serve_one(output int who);
        bit found = 0;
        who = -1;
        for (int t = 0; t < 8 && !found; t++) begin
            @(posedge clk); #2;
            if (s_read) found = 1;
        end
        if (!found) begin
            check("grant_timeout", 0, 1);
        end else begin
            logic [63:0] d;
            who = (s_address == ADDR_W'(29'h200)) ? 1 : 0;
            check("grant_nonowner_wait", (who == 0) ? m1_waitrequest : m0_waitrequest, 1);
            @(posedge clk); #1;
            d = {$urandom, $urandom};
            s_readdata      = d;
            s_readdatavalid = 1'b1;
            sb.push_back('{who, d});
            @(posedge clk); #1;
            s_readdatavalid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, exp_who;
        logic [63:0] d;

        vecs[0] = '{0, 29'h100,      8'd8, 0, 8};
        vecs[1] = '{1, 29'h2A0,      8'd3, 5, 3};
        vecs[2] = '{0, 29'h1FFFFFFF, 8'd2, 2, 2};
        vecs[3] = '{1, 29'h40,       8'd0, 0, 1};
        vecs[4] = '{0, 29'h8,        8'd1, 1, 1};

        // Reset: outputs idle, stray held clear even with valid beats arriving.
        rst = 1'b1;
        m0_read = 0; m1_read = 0;
        m0_address = '0; m1_address = '0; m0_burstcount = '0; m1_burstcount = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_s_read", s_read, 0);
        check("rst_s_address", s_address, 0);
        check("rst_s_burstcount", s_burstcount, 0);
        check("rst_busy", busy_o, 0);
        check("rst_stray", stray_o, 0);
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;
        rst = 1'b0;
        $display("[TB] reset checked");

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i].m, vecs[i].addr, vecs[i].bc, vecs[i].waits, vecs[i].beats);
        end
        check("no_stray_yet", stray_o, 0);

        // Reset after beat 3 of 8; the remaining 5 beats must be dropped as stray.
        @(posedge clk); #1;
        drive_req(0, 1'b1, 29'h500, 8'd8);
        @(posedge clk); #1;
        s_waitrequest = 1'b0;
        #1;
        check("abort_cmd", s_read, 1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 29'h500, 8'd8);
        for (int b = 0; b < 3; b++) begin
            if (b > 0) begin
                @(posedge clk); #1;
            end
            d = {$urandom, $urandom};
            s_readdata = d; s_readdatavalid = 1'b1;
            sb.push_back('{0, d});
        end
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_m0_wait", m0_waitrequest, 1);
        check("abort_stray", stray_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int b = 0; b < 5; b++) begin
            if (b > 0) begin
                @(posedge clk); #1;
            end
            s_readdata = {$urandom, $urandom}; s_readdatavalid = 1'b1;
        end
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;
        #1;
        check("stray_set", stray_o, 1);
        check("stray_busy", busy_o, 0);
        check("stray_sb", sb.size(), 0);
        $display("[TB] mid-burst reset, 5 stray beats");
        run_burst(1, 29'h3C0, 8'd4, 1, 4);
        check("stray_sticky", stray_o, 1);

        // Both requesters held high: grant order depends on the starve guard.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst2_stray", stray_o, 0);
        drive_req(0, 1'b1, 29'h100, 8'd1);
        drive_req(1, 1'b1, 29'h200, 8'd1);
        for (int k = 0; k < 10; k++) begin
            serve_one(who);
`ifdef ARB_STARVE_GUARD_EN
            exp_who = (k % 5 == 4) ? 1 : 0;
`else
            exp_who = 0;
`endif
            $display("[TB] grant %0d -> m%0d (expected m%0d)", k, who, exp_who);
            check("grant_order", who, exp_who);
        end
        drive_req(0, 1'b0, 29'h100, 8'd1);
        drive_req(1, 1'b0, 29'h200, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        check("final_sb", sb.size(), 0);
        check("final_busy", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sdram_read_arbiter.md
SDRAM_READ_ARBITER -- requirements
Module: sdram_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 29, the Avalon address width.
REQ-002 SHALL have parameter BURST_W, default 8, the burstcount width.
REQ-003 SHALL have parameter DATA_W, default 64, the readdata width.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive m0 bursts before m1 is granted.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have m0_address/m1_address  in  ADDR_W  requester read address; m0 is the pixel fetch requester, m1 is the auxiliary requester.
REQ-008 SHALL have m0_burstcount/m1_burstcount  in  BURST_W  requested beats.
REQ-009 SHALL have m0_read/m1_read  in  1  read request, held until accepted.
REQ-010 SHALL have m0_waitrequest/m1_waitrequest  out  1  command stall.
REQ-011 SHALL have m0_readdata/m1_readdata  out  DATA_W  return data.
REQ-012 SHALL have m0_readdatavalid/m1_readdatavalid  out  1  return beat valid.
REQ-013 SHALL have s_address  out  ADDR_W, s_burstcount  out  BURST_W and s_read  out  1, the command to the f2h_sdram port.
REQ-014 SHALL have s_waitrequest  in  1, s_readdata  in  DATA_W and s_readdatavalid  in  1, the response from the f2h_sdram port.
REQ-015 SHALL have busy_o  out  1  high while a burst is being issued or drained.
REQ-016 SHALL have stray_o  out  1  sticky flag: a readdatavalid arrived with no burst owner.

Function
REQ-017 SHALL implement the FSM IDLE -> CMD -> DATA -> IDLE, with one burst outstanding at most.
REQ-018 IDLE SHALL select the owner as follows: m1 when m1_read is high and either m0_read is low or the starve counter equals STARVE_LIMIT; otherwise m0 when m0_read is high; the owner SHALL be registered and the FSM SHALL move to CMD.
REQ-019 CMD SHALL drive s_read=1, with s_address and s_burstcount passed combinationally from the owner.
REQ-020 In CMD, owner waitrequest SHALL equal s_waitrequest.
REQ-021 Non-owner waitrequest SHALL be 1 in every state.
REQ-022 In CMD with s_waitrequest=0, the FSM SHALL latch the owner burstcount into the beat counter and move to DATA; a burstcount of 0 SHALL be latched as 1.
REQ-023 s_read SHALL be 0 outside CMD; s_address and s_burstcount SHALL be 0 when s_read=0.
REQ-024 s_readdata SHALL be broadcast unregistered to both m0_readdata and m1_readdata.
REQ-025 In DATA, owner readdatavalid SHALL equal s_readdatavalid, and non-owner readdatavalid SHALL be 0.
REQ-026 Each valid beat in DATA SHALL decrement the beat counter; on the beat where the counter equals 1, the FSM SHALL return to IDLE on the next edge.
REQ-027 Command-accept latency SHALL be: request seen in IDLE at cycle N, s_read high at cycle N+1.
REQ-028 s_readdatavalid outside DATA SHALL be discarded and SHALL set stray_o.
REQ-029 busy_o SHALL be 1 exactly in CMD and DATA.
REQ-030 The starve counter SHALL be 0..STARVE_LIMIT and saturating: +1 on an m0 accept while m1_read=1; cleared on an m1 accept or on an m0 accept with m1_read=0.

Reset
REQ-031 rst SHALL force IDLE, beat counter 0, starve counter 0, owner m0 and stray_o 0.
REQ-032 Under rst, outputs SHALL be: m0_waitrequest/m1_waitrequest=1, readdatavalids=0, s_read=0, s_address=0, s_burstcount=0, busy_o=0.
REQ-033 rst asserted mid-burst SHALL abort the burst within one cycle; remaining beats SHALL be treated as stray per REQ-028.

Configuration
REQ-034 Macro ARB_STARVE_GUARD_EN SHALL enable the starve counter and the m1 override of REQ-018 and REQ-030.
REQ-035 Without ARB_STARVE_GUARD_EN, arbitration SHALL be strict priority m0 > m1 and no counter SHALL be built.

Verification
REQ-036 SHALL cover: m0 single request, address 0x100, burstcount 8, s_waitrequest=0 -> s_read high for 1 cycle, 8 beats on m0_readdatavalid only, busy_o low the cycle after beat 8.
REQ-037 SHALL cover: both requesting continuously with ARB_STARVE_GUARD_EN -> grant order m0,m0,m0,m0,m1,m0..., and m1 is never starved longer than 4 bursts.
REQ-038 SHALL cover: the same stimulus without the macro -> m1 is never granted while m0_read is held high.
REQ-039 SHALL cover: s_waitrequest held 5 cycles in CMD -> owner waitrequest=1 for those 5 cycles, command stable, non-owner waitrequest=1 throughout.
REQ-040 SHALL cover: rst pulsed after beat 3 of 8, then 5 further s_readdatavalid beats -> no master readdatavalid, stray_o=1, and the next m1 burst completes correctly.
REQ-041 SHALL cover: m1 burstcount 0 -> treated as 1 beat, FSM back in IDLE after 1 beat.
